// File: rtl/ram_dp_sync_rw.sv
// Synchronous true dual-port RAM with a power-on clear sweep, byte-lane writes and
// defined same-address collision handling. Optional macro RAM_DP_SYNC_RW_OUT_REG_EN adds an output register stage.
module ram_dp_sync_rw #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 1 << ADDR_WIDTH,
  parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  init_done,
  output logic                  collision,
  input  logic                  cs_0,
  input  logic                  we_0,
  input  logic                  oe_0,
  input  logic [BE_WIDTH-1:0]   be_0,
  input  logic [ADDR_WIDTH-1:0] address_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rvalid_0,
  input  logic                  cs_1,
  input  logic                  we_1,
  input  logic                  oe_1,
  input  logic [BE_WIDTH-1:0]   be_1,
  input  logic [ADDR_WIDTH-1:0] address_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rvalid_1
);

  localparam int IDX_W = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W  = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(RAM_DEPTH - 1);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                 state;
  logic [IDX_W-1:0]       sweep_addr;
  logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

  logic                   run;
  logic                   wr_0, rd_0, wr_1, rd_1;
  logic                   in_range_0, in_range_1;
  logic [IDX_W-1:0]       idx_0, idx_1;
  logic [DATA_WIDTH-1:0]  rd_word_0, rd_word_1;
  logic                   coll_hit;

  logic [DATA_WIDTH-1:0]  rdata_s1_0, rdata_s1_1;
  logic                   rvalid_s1_0, rvalid_s1_1;
  logic                   coll_s1;

  // Port protocol: no backpressure. A request is taken on every RUN-state edge where
  // cs_N is high; we_N selects write, otherwise oe_N selects read. The read answer is a
  // one-cycle rvalid_N pulse with rdata_N, which is forced to 0 whenever rvalid_N is low.
  assign run        = (state == ST_RUN);
  assign wr_0       = run & cs_0 & we_0;
  assign rd_0       = run & cs_0 & oe_0 & ~we_0;
  assign wr_1       = run & cs_1 & we_1;
  assign rd_1       = run & cs_1 & oe_1 & ~we_1;
  assign in_range_0 = ({1'b0, address_0} < DEPTH_W);
  assign in_range_1 = ({1'b0, address_1} < DEPTH_W);
  assign idx_0      = address_0[IDX_W-1:0];
  assign idx_1      = address_1[IDX_W-1:0];
  assign rd_word_0  = in_range_0 ? mem[idx_0] : '0;
  assign rd_word_1  = in_range_1 ? mem[idx_1] : '0;

  // Both ports touch the same existing word and at least one of them writes.
  assign coll_hit = (wr_0 | rd_0) & (wr_1 | rd_1) & (wr_0 | wr_1) &
                    (address_0 == address_1) & in_range_0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_INIT;
      sweep_addr <= '0;
      init_done  <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          if (sweep_addr == LAST_IDX) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end else begin
            sweep_addr <= sweep_addr + 1'b1;
          end
        end
        ST_RUN: begin
          state     <= ST_RUN;
          init_done <= 1'b1;
        end
        default: begin
          state      <= ST_INIT;
          sweep_addr <= '0;
          init_done  <= 1'b0;
        end
      endcase
    end
  end

  // Port 1 lanes are applied first so that port 0 overrides any lane both ports enable.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[sweep_addr] <= '0;
    end else begin
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (wr_1 && in_range_1 && be_1[k])
          mem[idx_1][8*k +: 8] <= wdata_1[8*k +: 8];
      end
      for (int k = 0; k < BE_WIDTH; k++) begin
        if (wr_0 && in_range_0 && be_0[k])
          mem[idx_0][8*k +: 8] <= wdata_0[8*k +: 8];
      end
    end
  end

  // Reads sample the array before this edge's writes land, giving read-before-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_s1_0  <= '0;
      rdata_s1_1  <= '0;
      rvalid_s1_0 <= 1'b0;
      rvalid_s1_1 <= 1'b0;
      coll_s1     <= 1'b0;
    end else begin
      rdata_s1_0  <= rd_0 ? rd_word_0 : '0;
      rdata_s1_1  <= rd_1 ? rd_word_1 : '0;
      rvalid_s1_0 <= rd_0;
      rvalid_s1_1 <= rd_1;
      coll_s1     <= coll_hit;
    end
  end

`ifdef RAM_DP_SYNC_RW_OUT_REG_EN
  logic [DATA_WIDTH-1:0] rdata_s2_0, rdata_s2_1;
  logic                  rvalid_s2_0, rvalid_s2_1;
  logic                  coll_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_s2_0  <= '0;
      rdata_s2_1  <= '0;
      rvalid_s2_0 <= 1'b0;
      rvalid_s2_1 <= 1'b0;
      coll_s2     <= 1'b0;
    end else begin
      rdata_s2_0  <= rdata_s1_0;
      rdata_s2_1  <= rdata_s1_1;
      rvalid_s2_0 <= rvalid_s1_0;
      rvalid_s2_1 <= rvalid_s1_1;
      coll_s2     <= coll_s1;
    end
  end

  assign rdata_0   = rdata_s2_0;
  assign rdata_1   = rdata_s2_1;
  assign rvalid_0  = rvalid_s2_0;
  assign rvalid_1  = rvalid_s2_1;
  assign collision = coll_s2;
`else
  assign rdata_0   = rdata_s1_0;
  assign rdata_1   = rdata_s1_1;
  assign rvalid_0  = rvalid_s1_0;
  assign rvalid_1  = rvalid_s1_1;
  assign collision = coll_s1;
`endif

endmodule

// File: tb/tb_ram_dp_sync_rw.sv
// Bench for ram_dp_sync_rw: 16-bit words, 9-bit addresses over a 256-word array so that
// out-of-range addresses and byte lanes can be exercised.
module tb_ram_dp_sync_rw;

  localparam int DW    = 16;
  localparam int AW    = 9;
  localparam int DEPTH = 256;
  localparam int BW    = DW / 8;
  localparam int EW    = 2 * DW + 3;
`ifdef RAM_DP_SYNC_RW_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk;
  logic          rst_n;
  logic          init_done, collision;
  logic          cs_0, we_0, oe_0, cs_1, we_1, oe_1;
  logic [BW-1:0] be_0, be_1;
  logic [AW-1:0] address_0, address_1;
  logic [DW-1:0] wdata_0, wdata_1, rdata_0, rdata_1;
  logic          rvalid_0, rvalid_1;

  int n_checks = 0;
  int n_fails  = 0;

  // Scoreboard: one expected output word per clock edge {collision, rvalid_1, rdata_1, rvalid_0, rdata_0}
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] model_mem [DEPTH];
  int            edge_n;

  ram_dp_sync_rw #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done), .collision(collision),
    .cs_0(cs_0), .we_0(we_0), .oe_0(oe_0), .be_0(be_0), .address_0(address_0),
    .wdata_0(wdata_0), .rdata_0(rdata_0), .rvalid_0(rvalid_0),
    .cs_1(cs_1), .we_1(we_1), .oe_1(oe_1), .be_1(be_1), .address_1(address_1),
    .wdata_1(wdata_1), .rdata_1(rdata_1), .rvalid_1(rvalid_1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- check helpers ----------------
  task automatic check1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask

  task automatic checkd(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int i = 0; i < LAT - 1; i++) exp_q.push_back('0);
    edge_n = 0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
  endtask

  // ---------------- reference model ----------------
  logic [EW-1:0] m_e;
  logic          m_w0, m_r0, m_w1, m_r1, m_in0, m_in1;

  always @(posedge clk) begin
    if (rst_n) begin
      m_e = '0;
      if (edge_n >= DEPTH) begin
        m_w0  = cs_0 && we_0;
        m_r0  = cs_0 && oe_0 && !we_0;
        m_w1  = cs_1 && we_1;
        m_r1  = cs_1 && oe_1 && !we_1;
        m_in0 = int'(address_0) < DEPTH;
        m_in1 = int'(address_1) < DEPTH;
        if (m_r0 && m_in0) m_e[DW-1:0]       = model_mem[address_0[7:0]];
        if (m_r1 && m_in1) m_e[2*DW:DW+1]    = model_mem[address_1[7:0]];
        m_e[DW]       = m_r0;
        m_e[2*DW+1]   = m_r1;
        m_e[2*DW+2]   = (m_w0 || m_r0) && (m_w1 || m_r1) && (m_w0 || m_w1) &&
                        (address_0 == address_1) && m_in0;
        for (int k = 0; k < BW; k++)
          if (m_w1 && m_in1 && be_1[k]) model_mem[address_1[7:0]][8*k +: 8] = wdata_1[8*k +: 8];
        for (int k = 0; k < BW; k++)
          if (m_w0 && m_in0 && be_0[k]) model_mem[address_0[7:0]][8*k +: 8] = wdata_0[8*k +: 8];
      end
      exp_q.push_back(m_e);
      edge_n++;
    end
  end

  // ---------------- compare process ----------------
  logic [EW-1:0] c_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      check1("rst_init_done", init_done, 1'b0);
      check1("rst_collision", collision, 1'b0);
      check1("rst_rvalid_0", rvalid_0, 1'b0);
      check1("rst_rvalid_1", rvalid_1, 1'b0);
      checkd("rst_rdata_0", rdata_0, '0);
      checkd("rst_rdata_1", rdata_1, '0);
    end else if (exp_q.size() > 0) begin
      c_e = exp_q.pop_front();
      checkd("rdata_0", rdata_0, c_e[DW-1:0]);
      check1("rvalid_0", rvalid_0, c_e[DW]);
      checkd("rdata_1", rdata_1, c_e[2*DW:DW+1]);
      check1("rvalid_1", rvalid_1, c_e[2*DW+1]);
      check1("collision", collision, c_e[2*DW+2]);
      check1("init_done", init_done, edge_n >= DEPTH);
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 6)      return AW'($urandom_range(0, 7));
    else if (r < 8) return AW'($urandom_range(0, DEPTH - 1));
    else            return AW'($urandom_range(DEPTH, (1 << AW) - 1));
  endfunction

  task automatic set_ports(input logic c0, w0, o0, input logic [BW-1:0] b0,
                           input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                           input logic c1, w1, o1, input logic [BW-1:0] b1,
                           input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    cs_0 = c0; we_0 = w0; oe_0 = o0; be_0 = b0; address_0 = a0; wdata_0 = d0;
    cs_1 = c1; we_1 = w1; oe_1 = o1; be_1 = b1; address_1 = a1; wdata_1 = d1;
  endtask

  task automatic idle_ports();
    set_ports(0, 0, 0, '0, '0, '0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic rand_ports();
    set_ports($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              BW'($urandom_range(0, 3)), pick_addr(), DW'($urandom),
              $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              BW'($urandom_range(0, 3)), pick_addr(), DW'($urandom));
  endtask

  task automatic op(input logic c0, w0, o0, input logic [BW-1:0] b0,
                    input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                    input logic c1, w1, o1, input logic [BW-1:0] b1,
                    input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    @(negedge clk);
    set_ports(c0, w0, o0, b0, a0, d0, c1, w1, o1, b1, a1, d1);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    idle_ports();
  endtask

  // Issue one read and compare the answer against a hand-computed literal.
  task automatic read_lit(input int port, input logic [AW-1:0] a, input logic [DW-1:0] v,
                          input string nm);
    if (port == 0) op(1, 0, 1, '0, a, '0, 0, 0, 0, '0, '0, '0);
    else           op(0, 0, 0, '0, '0, '0, 1, 0, 1, '0, a, '0);
    idle_cycle();
    repeat (LAT - 1) @(negedge clk);
    if (port == 0) begin
      check1({nm, "_rvalid"}, rvalid_0, 1'b1);
      checkd(nm, rdata_0, v);
    end else begin
      check1({nm, "_rvalid"}, rvalid_1, 1'b1);
      checkd(nm, rdata_1, v);
    end
  endtask

  task automatic assert_reset(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check1({nm, "_init_done"}, init_done, 1'b0);
    check1({nm, "_rvalid_0"}, rvalid_0, 1'b0);
    check1({nm, "_rvalid_1"}, rvalid_1, 1'b0);
    checkd({nm, "_rdata_1"}, rdata_1, '0);
    check1({nm, "_collision"}, collision, 1'b0);
  endtask

  // Release reset and run through the clear sweep with random (dropped) traffic.
  task automatic release_and_sweep(input string nm);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      @(negedge clk);
      if (i < DEPTH) rand_ports();
      else           idle_ports();
      if (i == DEPTH - 1) check1({nm, "_init_low_256"}, init_done, 1'b0);
      if (i == DEPTH)     check1({nm, "_init_high_257"}, init_done, 1'b1);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    idle_ports();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    release_and_sweep("por");

    read_lit(1, 9'h037, 16'h0000, "rd_after_init_37");

    op(1, 1, 0, 2'b01, 9'h010, 16'h00A5, 0, 0, 0, '0, '0, '0);
    read_lit(1, 9'h010, 16'h00A5, "wr_then_rd_10");

    op(1, 1, 0, 2'b11, 9'h020, 16'h0011, 1, 1, 0, 2'b11, 9'h020, 16'h0022);
    idle_cycle();
    repeat (LAT - 1) @(negedge clk);
    check1("coll_ww_pulse", collision, 1'b1);
    @(negedge clk);
    check1("coll_ww_once", collision, 1'b0);
    read_lit(0, 9'h020, 16'h0011, "ww_port0_wins");

    op(1, 1, 0, 2'b11, 9'h030, 16'h0055, 0, 0, 0, '0, '0, '0);
    op(1, 1, 0, 2'b11, 9'h030, 16'h00AA, 1, 0, 1, '0, 9'h030, '0);
    idle_cycle();
    repeat (LAT - 1) @(negedge clk);
    checkd("rw_old_data", rdata_1, 16'h0055);
    check1("rw_coll", collision, 1'b1);
    read_lit(0, 9'h030, 16'h00AA, "rw_new_data");

    op(0, 0, 0, '0, '0, '0, 1, 1, 0, 2'b11, 9'h004, 16'h1234);
    op(1, 1, 0, 2'b10, 9'h004, 16'hABCD, 0, 0, 0, '0, '0, '0);
    read_lit(1, 9'h004, 16'hAB34, "byte_lane_hi");
    op(1, 1, 0, 2'b00, 9'h004, 16'hFFFF, 0, 0, 0, '0, '0, '0);
    read_lit(0, 9'h004, 16'hAB34, "be_zero_noop");

    op(1, 1, 0, 2'b11, 9'h104, 16'h7777, 0, 0, 0, '0, '0, '0);
    read_lit(1, 9'h004, 16'hAB34, "oor_write_ignored");
    read_lit(0, 9'h1F0, 16'h0000, "oor_read_zero");

    op(1, 0, 1, '0, 9'h010, '0, 1, 0, 1, '0, 9'h010, '0);
    idle_cycle();
    repeat (LAT - 1) @(negedge clk);
    check1("rr_no_coll", collision, 1'b0);
    checkd("rr_port0", rdata_0, 16'h00A5);
    checkd("rr_port1", rdata_1, 16'h00A5);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rand_ports();
    end
    idle_cycle();

    assert_reset("run_reset");
    repeat (2) @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      rand_ports();
    end
    assert_reset("mid_sweep_reset");
    repeat (2) @(negedge clk);
    release_and_sweep("resweep");

    read_lit(0, 9'h030, 16'h0000, "cleared_after_reset_30");
    read_lit(1, 9'h004, 16'h0000, "cleared_after_reset_04");

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rand_ports();
    end
    idle_cycle();
    repeat (LAT + 2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
